// File: rtl/tuner_pkg.sv
// Shared types and default constants for the zero-crossing period tuner.
// The state enum is used by zero_cross_period; the defaults seed its parameters.
package tuner_pkg;

  typedef enum logic [0:0] {
    SEARCH  = 1'b0,
    MEASURE = 1'b1
  } zc_state_e;

  localparam int WIDTH_DEFAULT        = 12;
  localparam int PERIOD_WIDTH_DEFAULT = 10;
  localparam int HYST_DEFAULT         = 64;

endpackage : tuner_pkg

// File: rtl/zc_period_counter.sv
// Sample counter for the period measurement: synchronous clear (priority), increment,
// and a flag one below the all-ones value so the owner can stop before the count wraps.
module zc_period_counter
  import tuner_pkg::*;
#(
  parameter int period_width_p = PERIOD_WIDTH_DEFAULT
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic                      clr,
  input  logic                      inc,
  output logic [period_width_p-1:0] cnt,
  output logic                      at_max
);

  localparam logic [period_width_p-1:0] MaxCnt = {{(period_width_p-1){1'b1}}, 1'b0};
  localparam logic [period_width_p-1:0] One    = period_width_p'(1);

  logic [period_width_p-1:0] cnt_r;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (inc) begin
      cnt_r <= cnt_r + One;
    end
  end

  assign cnt    = cnt_r;
  assign at_max = (cnt_r == MaxCnt);

endmodule : zc_period_counter

// File: rtl/zero_cross_period.sv
// Measures the period of a signed sample stream between hysteresis-armed rising zero
// crossings. reset_ni is asserted asynchronously; its release must be synchronised upstream.
module zero_cross_period
  import tuner_pkg::*;
#(
  parameter int width_p        = WIDTH_DEFAULT,
  parameter int period_width_p = PERIOD_WIDTH_DEFAULT,
  parameter int hyst_p         = HYST_DEFAULT
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic signed [width_p-1:0] data_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic [period_width_p-1:0] period_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      timeout_o,
  output logic                      overrun_o
);

  localparam logic signed [width_p-1:0] NegHyst = width_p'(-hyst_p);
  localparam logic [period_width_p-1:0] One     = period_width_p'(1);

  zc_state_e                 state_r, state_next;
  logic                      arm_r, arm_next;
  logic [period_width_p-1:0] cnt;
  logic                      cnt_at_max;
  logic                      cnt_clr, cnt_inc;
  logic                      new_result, timeout_next;
  logic                      deep_negative, crossing;
  logic                      load_result, drop_result;
  logic [period_width_p-1:0] period_r;
  logic                      valid_r, timeout_r, overrun_r;

  // Samples in [-hyst_p, -1] neither arm nor cross.
  assign deep_negative = (data_i < NegHyst);
  assign crossing      = valid_i & arm_r & ~data_i[width_p-1];

  always_comb begin
    arm_next = arm_r;
    if (valid_i) begin
      if (deep_negative) begin
        arm_next = 1'b1;
      end else if (crossing) begin
        arm_next = 1'b0;
      end
    end
  end

  always_comb begin
    state_next   = state_r;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    new_result   = 1'b0;
    timeout_next = 1'b0;
    if (valid_i) begin
      unique case (state_r)
        SEARCH: begin
          if (crossing) begin
            state_next = MEASURE;
            cnt_clr    = 1'b1;
          end
        end
        MEASURE: begin
          if (crossing) begin
            new_result = 1'b1;
            cnt_clr    = 1'b1;
          end else if (cnt_at_max) begin
            // Give up before the counter wraps; the arm state is kept.
            timeout_next = 1'b1;
            state_next   = SEARCH;
            cnt_clr      = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: begin
          state_next = SEARCH;
          cnt_clr    = 1'b1;
        end
      endcase
    end
  end

  zc_period_counter #(
    .period_width_p(period_width_p)
  ) u_counter (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .cnt     (cnt),
    .at_max  (cnt_at_max)
  );

  // A held result is only replaced in the cycle it is being consumed.
  assign load_result = new_result & (~valid_r | ready_i);
  assign drop_result = new_result & valid_r & ~ready_i;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_r   <= SEARCH;
      arm_r     <= 1'b0;
      period_r  <= '0;
      valid_r   <= 1'b0;
      timeout_r <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      state_r   <= state_next;
      arm_r     <= arm_next;
      timeout_r <= timeout_next;
      overrun_r <= drop_result;
      if (load_result) begin
        period_r <= cnt + One;
        valid_r  <= 1'b1;
      end else if (valid_r && ready_i) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign ready_o   = 1'b1;
  assign period_o  = period_r;
  assign valid_o   = valid_r;
  assign timeout_o = timeout_r;
  assign overrun_o = overrun_r;

endmodule : zero_cross_period
